// File: rtl/gray_step_monitor.sv
// Gray-coded position stream monitor: decodes each accepted sample, classifies
// the transition from the previous sample, and keeps step/error counters plus lock state.
module gray_step_monitor #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             in_valid,
  input  logic             clr,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             step,
  output logic             dir_up,
  output logic             err,
  output logic             locked,
  output logic [CNT_W-1:0] step_count,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state_dbg
);

  // Handshake: a sample is taken on every rising edge where in_valid is high
  // and clr is low; there is no back-pressure, so a sample can arrive every cycle.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] BIN_ONE = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_g_q, prev_g_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             bin_valid_q, bin_valid_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic             dir_up_q, dir_up_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] new_bin;
  logic [WIDTH-1:0] diff;
  logic             same_code;
  logic             one_bit;
  logic             is_up;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    new_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      new_bin[i] = ^(gray_in >> i);
    end
  end

  assign diff      = gray_in ^ prev_g_q;
  assign same_code = (diff == '0);
  assign one_bit   = !same_code && ((diff & (diff - BIN_ONE)) == '0);
  assign is_up     = (new_bin == (bin_q + BIN_ONE));

  always_comb begin
    state_d     = state_q;
    prev_g_d    = prev_g_q;
    bin_d       = bin_q;
    bin_valid_d = bin_valid_q;
    step_d      = 1'b0;
    err_d       = 1'b0;
    dir_up_d    = dir_up_q;
    step_cnt_d  = step_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (clr) begin
      state_d     = IDLE;
      prev_g_d    = '0;
      bin_d       = '0;
      bin_valid_d = 1'b0;
      dir_up_d    = 1'b1;
      step_cnt_d  = '0;
      err_cnt_d   = '0;
    end else if (in_valid) begin
      case (state_q)
        IDLE: begin
          prev_g_d    = gray_in;
          bin_d       = new_bin;
          bin_valid_d = 1'b1;
          state_d     = ACQ;
        end
        ACQ, TRACK: begin
          if (same_code) begin
            bin_d = new_bin;
          end else if (one_bit) begin
            step_d     = 1'b1;
            step_cnt_d = step_cnt_q + CNT_ONE;
            dir_up_d   = is_up;
            prev_g_d   = gray_in;
            bin_d      = new_bin;
            state_d    = TRACK;
          end else begin
            err_d     = 1'b1;
            err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CNT_ONE;
            prev_g_d  = gray_in;
            bin_d     = new_bin;
            state_d   = ACQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prev_g_q    <= '0;
      bin_q       <= '0;
      bin_valid_q <= 1'b0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
      dir_up_q    <= 1'b1;
      step_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_g_q    <= prev_g_d;
      bin_q       <= bin_d;
      bin_valid_q <= bin_valid_d;
      step_q      <= step_d;
      err_q       <= err_d;
      dir_up_q    <= dir_up_d;
      step_cnt_q  <= step_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bin_out    = bin_q;
  assign bin_valid  = bin_valid_q;
  assign step       = step_q;
  assign err        = err_q;
  assign dir_up     = dir_up_q;
  assign locked     = (state_q == TRACK);
  assign step_count = step_cnt_q;
  assign err_count  = err_cnt_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_gray_step_monitor.sv
// Bench for gray_step_monitor: a behavioural position model checked every cycle
// against two instances (8-bit and 2-bit counters), plus hand-computed directed checks.
module tb_gray_step_monitor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] gray_in = '0;
  logic         in_valid = 1'b0;
  logic         clr = 1'b0;

  logic [W-1:0] bin_out, bin_out_s;
  logic         bin_valid, bin_valid_s, step, step_s, dir_up, dir_up_s;
  logic         err, err_s, locked, locked_s;
  logic [7:0]   step_count, err_count;
  logic [1:0]   step_count_s, err_count_s;
  logic [1:0]   state_dbg, state_dbg_s;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  gray_step_monitor #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .in_valid(in_valid), .clr(clr),
    .bin_out(bin_out), .bin_valid(bin_valid), .step(step), .dir_up(dir_up),
    .err(err), .locked(locked), .step_count(step_count), .err_count(err_count),
    .state_dbg(state_dbg)
  );

  gray_step_monitor #(.WIDTH(W), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .in_valid(in_valid), .clr(clr),
    .bin_out(bin_out_s), .bin_valid(bin_valid_s), .step(step_s), .dir_up(dir_up_s),
    .err(err_s), .locked(locked_s), .step_count(step_count_s), .err_count(err_count_s),
    .state_dbg(state_dbg_s)
  );

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int g2b(input logic [W-1:0] g);
    int b = 0;
    for (int s = 0; s < W; s++) b = b ^ int'(g >> s);
    return b;
  endfunction

  function automatic logic [W-1:0] b2g(input int b);
    return W'((b ^ (b >> 1)) & ((1 << W) - 1));
  endfunction

  // ---------------- behavioural model ----------------
  // Tracks the position in plain integers; counters are kept unbounded and
  // folded to each instance's width at compare time.
  int m_bin, m_sc, m_ec;
  bit m_have, m_locked, m_binv, m_step, m_err, m_dir;

  always @(posedge clk or negedge rst_n) begin
    int gb, d;
    if (!rst_n || clr) begin
      m_bin = 0; m_sc = 0; m_ec = 0; m_have = 0; m_locked = 0;
      m_binv = 0; m_step = 0; m_err = 0; m_dir = 1;
    end else if (in_valid) begin
      gb = g2b(gray_in);
      m_step = 0; m_err = 0;
      if (!m_have) begin
        m_have = 1; m_binv = 1; m_bin = gb;
      end else begin
        d = $countones(gray_in ^ b2g(m_bin));
        if (d == 1) begin
          m_step = 1; m_sc++; m_locked = 1;
          m_dir = (((gb - m_bin + (1 << W)) % (1 << W)) == 1);
        end else if (d >= 2) begin
          m_err = 1; m_ec++; m_locked = 0;
        end
        m_bin = gb;
      end
    end else begin
      m_step = 0; m_err = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("bin_out", bin_out, m_bin);
    chk("bin_valid", bin_valid, m_binv);
    chk("step", step, m_step);
    chk("err", err, m_err);
    chk("dir_up", dir_up, m_dir);
    chk("locked", locked, m_locked);
    chk("step_count", step_count, m_sc % 256);
    chk("err_count", err_count, (m_ec > 255) ? 255 : m_ec);
    chk("bin_out_s", bin_out_s, m_bin);
    chk("step_s", step_s, m_step);
    chk("err_s", err_s, m_err);
    chk("step_count_s", step_count_s, m_sc % 4);
    chk("err_count_s", err_count_s, (m_ec > 3) ? 3 : m_ec);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [W-1:0] g, input logic c);
    @(negedge clk);
    in_valid = v; gray_in = g; clr = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0; clr = 1'b0;
  endtask

  task automatic send(input int b);
    drive(1'b1, b2g(b), 1'b0);
  endtask

  task automatic do_clr();
    drive(1'b0, '0, 1'b1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bin_out"}, bin_out, 0);
    chk({tag, "_bin_valid"}, bin_valid, 0);
    chk({tag, "_step"}, step, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_dir_up"}, dir_up, 1);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_step_count"}, step_count, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_state"}, state_dbg, 0);
  endtask

  // ---------------- scoreboard for gap equivalence ----------------
  logic [23:0] exp_q[$];
  int gap_seq[10] = '{3, 4, 4, 5, 9, 8, 7, 7, 12, 13};
  int sat_exp[5]  = '{1, 2, 3, 3, 3};

  function automatic logic [23:0] snap();
    return {bin_out, step, err, dir_up, locked, step_count, err_count};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    @(posedge clk); #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full ascending sweep.
    for (int b = 0; b < 16; b++) begin
      send(b);
      if (b == 0) begin
        chk("sweep_first_step", step, 0);
        chk("sweep_first_locked", locked, 0);
        chk("sweep_first_bin_valid", bin_valid, 1);
      end else if (b == 1) begin
        chk("sweep_second_locked", locked, 1);
      end
    end
    chk("sweep_bin_out", bin_out, 15);
    chk("sweep_step_count", step_count, 15);
    chk("sweep_dir_up", dir_up, 1);
    chk("sweep_err_count", err_count, 0);

    // Wrap-around in both directions.
    do_clr();
    send(14); send(15);
    send(0);
    chk("wrap_up_step", step, 1);
    chk("wrap_up_dir", dir_up, 1);
    send(1);
    send(1);
    chk("repeat_no_step", step, 0);
    send(0);
    chk("down_dir", dir_up, 0);
    send(15);
    chk("wrap_down_step", step, 1);
    chk("wrap_down_dir", dir_up, 0);

    // Illegal jump from bin 6 (gray 0101) to gray 0000.
    do_clr();
    send(5); send(6);
    chk("jump_pre_locked", locked, 1);
    drive(1'b1, 4'b0000, 1'b0);
    chk("jump_err", err, 1);
    chk("jump_err_count", err_count, 1);
    chk("jump_locked", locked, 0);
    chk("jump_bin_out", bin_out, 0);
    send(1);
    chk("relock_step", step, 1);
    chk("relock_locked", locked, 1);

    // Gap-free reference run, then the same samples separated by idle cycles.
    do_clr();
    foreach (gap_seq[i]) begin
      send(gap_seq[i]);
      exp_q.push_back(snap());
    end
    do_clr();
    foreach (gap_seq[i]) begin
      repeat ($urandom_range(1, 3)) drive(1'b0, W'($urandom_range(0, 15)), 1'b0);
      send(gap_seq[i]);
      if (exp_q.size() > 0) chk("gap_snapshot", int'(snap()), int'(exp_q.pop_front()));
      else chk("gap_queue_empty", 1, 0);
    end

    // Clear together with a valid sample while locked.
    do_clr();
    send(2); send(3); send(2);
    chk("pre_clr_locked", locked, 1);
    drive(1'b1, b2g(3), 1'b1);
    chk_reset_vals("clr");
    send(8);
    chk("clr_reacq_step", step, 0);
    chk("clr_reacq_bin", bin_out, 8);
    chk("clr_reacq_valid", bin_valid, 1);

    // Asynchronous reset mid-stream, away from any clock edge.
    send(9); send(8);
    chk("pre_rst_dir", dir_up, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    send(7);
    chk("rst_reacq_step", step, 0);
    chk("rst_reacq_bin", bin_out, 7);
    chk("rst_reacq_locked", locked, 0);

    // Error counter saturation on the 2-bit instance.
    do_clr();
    drive(1'b1, 4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, (k % 2 == 0) ? 4'b0011 : 4'b0000, 1'b0);
      chk("sat_err_pulse", err_s, 1);
      chk("sat_err_count", err_count_s, sat_exp[k]);
    end
    chk("sat_wide_err_count", err_count, 5);

    repeat (3) drive(1'b0, '0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
